// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state, queue entry, address helpers.
package fetch_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-aligned and inside the instruction memory.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch queue of {pc, instr} entries; wrap-bit pointers, registered head, synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW:0]    wptr, rptr;
  logic           do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // At full, a same-cycle pop frees the slot being overwritten.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the pc, captures combinational imem data into a queue,
// hands {pc, instr} to decode, and handles redirects and bad-address faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 256,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         legal, push, pop, full, empty;
  fetch_entry_t head, wr_entry;

  assign legal     = addr_ok(pc, MEM_WORDS);
  assign imem_addr = pc;
  assign pop       = out_valid && out_ready;
  assign wr_entry  = '{pc: pc, instr: imem_instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Redirect wins over push/fault; a same-cycle pop is still honoured before the flush.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    if (redirect_valid) begin
      state_nxt = FETCH;
      pc_nxt    = redirect_pc;
    end else if (state == FETCH) begin
      if (!legal) begin
        state_nxt = FAULT;
      end else if (!full || pop) begin
        push   = 1'b1;
        pc_nxt = pc + WORD_BYTES;
      end
    end
  end

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = (state == FAULT);
  assign fault_pc  = fault ? pc : 32'h0;

endmodule
